sprite_plotter: RTL and testbench



---
 rtl/sprite_plotter.sv | 177 +++++++++++++++++
 tb/tb_sprite_plotter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// sprite_plotter: per-object draw engine.
// Scans a WIDTH x HEIGHT rectangle at the object's origin one pixel per
// cycle, then pulses done. Also owns the origin register and steps it on
// granted moves, with wrap-around at the screen edges (320x240).
module sprite_plotter #(
  parameter int         WIDTH         = 27,
  parameter int         HEIGHT        = 5,
  parameter int         X_INIT        = 0,
  parameter int         Y_INIT        = 100,
  parameter int         STEP          = 4,
  parameter logic [2:0] SPRITE_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       erase,
  input  logic       can_move,
  input  logic       move_req,
  input  logic [1:0] dir,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [8:0] x_final,
  output logic [7:0] y_final,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] CX_LAST = 6'(WIDTH - 1);
  localparam logic [5:0] CY_LAST = 6'(HEIGHT - 1);
  localparam logic [9:0] STEP_W  = 10'(STEP);
  localparam logic [9:0] X_MAX   = 10'(320 - WIDTH);
  localparam logic [9:0] Y_MAX   = 10'(240 - HEIGHT);
  localparam logic [8:0] X_RST   = 9'(X_INIT);
  localparam logic [7:0] Y_RST   = 8'(Y_INIT);

  state_t     state_q, state_d;
  logic [5:0] cx_q, cx_d;
  logic [5:0] cy_q, cy_d;
  logic       erase_l_q, erase_l_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  logic [9:0] x_ext_s, y_ext_s;
  logic [9:0] x_inc_s, x_dec_s, y_inc_s, y_dec_s;

  // Next-state logic for the scan FSM and the pixel counters.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    erase_l_d = erase_l_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = SCAN;
          cx_d      = 6'd0;
          cy_d      = 6'd0;
          erase_l_d = erase;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Dropping enable aborts the scan without a done pulse.
        if (!enable) begin
          state_d = IDLE;
        end else if (cx_q == CX_LAST) begin
          cx_d = 6'd0;
          cy_d = cy_q + 6'd1;
          if (cy_q == CY_LAST) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end else begin
          cx_d = cx_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Origin update: granted moves only in IDLE, wrapping at the screen edges.
  always_comb begin
    x_ext_s = {1'b0, x_q};
    y_ext_s = {2'b00, y_q};
    x_inc_s = x_ext_s + STEP_W;
    x_dec_s = x_ext_s - STEP_W;
    y_inc_s = y_ext_s + STEP_W;
    y_dec_s = y_ext_s - STEP_W;
    x_d     = x_q;
    y_d     = y_q;
    if (can_move && move_req && (state_q == IDLE)) begin
      case (dir)
        2'd0: begin
          if (x_inc_s <= X_MAX) begin
            x_d = x_inc_s[8:0];
          end else begin
            x_d = 9'd0;
          end
        end
        2'd1: begin
          if (x_ext_s >= STEP_W) begin
            x_d = x_dec_s[8:0];
          end else begin
            x_d = X_MAX[8:0];
          end
        end
        2'd2: begin
          if (y_inc_s <= Y_MAX) begin
            y_d = y_inc_s[7:0];
          end else begin
            y_d = 8'd0;
          end
        end
        2'd3: begin
          if (y_ext_s >= STEP_W) begin
            y_d = y_dec_s[7:0];
          end else begin
            y_d = Y_MAX[7:0];
          end
        end
        default: begin
          x_d = x_q;
          y_d = y_q;
        end
      endcase
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // State, counter and origin registers with asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cx_q      <= 6'd0;
      cy_q      <= 6'd0;
      erase_l_q <= 1'b0;
      x_q       <= X_RST;
      y_q       <= Y_RST;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      erase_l_q <= erase_l_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Moore output decode straight from the registers.
  always_comb begin
    x       = x_q;
    y       = y_q;
    x_final = x_q + {3'b000, cx_q};
    y_final = y_q + {2'b00, cy_q};
    colour  = erase_l_q ? BG_COLOUR : SPRITE_COLOUR;
    plot    = (state_q == SCAN);
    done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: table-driven move vectors plus a
// pixel scoreboard for draw/erase/abort/reset-mid-scan sequences.
module tb_sprite_plotter;

  localparam int         W    = 27;
  localparam int         H    = 5;
  localparam int         NPIX = W * H;
  localparam logic [2:0] SP   = 3'b100;
  localparam logic [2:0] BG   = 3'b000;
  localparam logic [1:0] RT = 2'd0, LF = 2'd1, DN = 2'd2, UP = 2'd3;

  logic       clock = 1'b0;
  logic       resetn, enable, erase, can_move, move_req;
  logic [1:0] dir;
  logic [8:0] x, x_final;
  logic [7:0] y, y_final;
  logic [2:0] colour;
  logic       plot, done;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [1:0] dir;
    logic       req;
    logic       can;
    logic [8:0] ex;
    logic [7:0] ey;
  } mv_t;

  pix_t exp_q[$];
  mv_t  vec[10];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [8:0] m_x;
  logic [7:0] m_y;

  sprite_plotter dut (
    .clock(clock), .resetn(resetn), .enable(enable), .erase(erase),
    .can_move(can_move), .move_req(move_req), .dir(dir),
    .x(x), .y(y), .x_final(x_final), .y_final(y_final),
    .colour(colour), .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and score any pixel the DUT presents.
  task automatic step();
    pix_t p;
    @(posedge clock);
    #2;
    if (plot) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_plot", plot, 1'b0);
      end else begin
        p = exp_q.pop_front();
        chk("pix_x", x_final, p.x);
        chk("pix_y", y_final, p.y);
        chk("pix_colour", colour, p.c);
      end
    end
    if (done) chk("done_without_plot", plot, 1'b0);
  endtask

  task automatic do_move(input logic [1:0] d, input logic rq, input logic cm);
    dir = d; move_req = rq; can_move = cm;
    step();
    can_move = 1'b0; move_req = 1'b0;
  endtask

  // Run a scan from the model origin. abort_after>0 drops enable after that
  // many pixels; mv_at==0 issues a move with the enable, mv_at>0 mid-scan.
  task automatic scan(input logic er, input int abort_after, input int mv_at, input string tag);
    int plots, dcnt, dcyc, n;
    if (mv_at == 0) begin can_move = 1'b1; move_req = 1'b1; dir = RT; end
    n = (abort_after > 0) ? abort_after : NPIX;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{x: m_x + 9'(i % W), y: m_y + 8'(i / W), c: (er ? BG : SP)});
    erase = er; enable = 1'b1;
    plots = 0; dcnt = 0; dcyc = 0;
    for (int cyc = 1; cyc <= n + 4; cyc++) begin
      step();
      if (cyc == 1 && mv_at == 0) begin can_move = 1'b0; move_req = 1'b0; end
      if (mv_at > 0 && cyc == mv_at) begin can_move = 1'b1; move_req = 1'b1; dir = RT; end
      if (mv_at > 0 && cyc == mv_at + 1) begin can_move = 1'b0; move_req = 1'b0; end
      if (plot) plots++;
      if (done) begin dcnt++; dcyc = cyc; enable = 1'b0; end
      if (cyc == 3) erase = ~er;
      if (abort_after > 0 && plots == abort_after) enable = 1'b0;
    end
    erase = 1'b0; enable = 1'b0;
    chk({tag, "_plot_count"}, plots, n);
    chk({tag, "_done_count"}, dcnt, (abort_after > 0) ? 0 : 1);
    if (abort_after == 0) chk({tag, "_done_cycle"}, dcyc, NPIX + 1);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_origin_x"}, x, m_x);
    chk({tag, "_origin_y"}, y, m_y);
  endtask

  initial begin
    vec[0] = '{RT, 1'b1, 1'b1, 9'd4,   8'd100};
    vec[1] = '{RT, 1'b0, 1'b1, 9'd4,   8'd100};
    vec[2] = '{RT, 1'b1, 1'b0, 9'd4,   8'd100};
    vec[3] = '{LF, 1'b1, 1'b1, 9'd0,   8'd100};
    vec[4] = '{LF, 1'b1, 1'b1, 9'd293, 8'd100};
    vec[5] = '{LF, 1'b1, 1'b1, 9'd289, 8'd100};
    vec[6] = '{RT, 1'b1, 1'b1, 9'd293, 8'd100};
    vec[7] = '{RT, 1'b1, 1'b1, 9'd0,   8'd100};
    vec[8] = '{DN, 1'b1, 1'b1, 9'd0,   8'd104};
    vec[9] = '{UP, 1'b1, 1'b1, 9'd0,   8'd100};

    resetn = 1'b1; enable = 1'b0; erase = 1'b0;
    can_move = 1'b0; move_req = 1'b0; dir = 2'd0;
    #3 resetn = 1'b0;
    step(); step();
    chk("rst_plot", plot, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_x", x, 9'd0);
    chk("rst_y", y, 8'd100);
    chk("rst_x_final", x_final, 9'd0);
    chk("rst_y_final", y_final, 8'd100);
    chk("rst_colour", colour, SP);
    resetn = 1'b1;
    step();

    m_x = 9'd0; m_y = 8'd100;
    scan(1'b0, 0, -1, "draw");
    scan(1'b1, 0, -1, "erase");

    for (int i = 0; i < 10; i++) begin
      do_move(vec[i].dir, vec[i].req, vec[i].can);
      chk($sformatf("move_vec%0d_x", i), x, vec[i].ex);
      chk($sformatf("move_vec%0d_y", i), y, vec[i].ey);
    end

    repeat (25) do_move(UP, 1'b1, 1'b1);
    chk("up_to_zero", y, 8'd0);
    do_move(UP, 1'b1, 1'b1);  chk("up_wrap_from0", y, 8'd235);
    do_move(UP, 1'b1, 1'b1);  chk("up_step", y, 8'd231);
    do_move(DN, 1'b1, 1'b1);  chk("down_to_max", y, 8'd235);
    do_move(DN, 1'b1, 1'b1);  chk("down_wrap", y, 8'd0);
    do_move(UP, 1'b1, 1'b1);
    repeat (58) do_move(UP, 1'b1, 1'b1);
    chk("up_to_three", y, 8'd3);
    do_move(UP, 1'b1, 1'b1);  chk("up_wrap_from3", y, 8'd235);
    repeat (73) do_move(RT, 1'b1, 1'b1);
    chk("right_to_292", x, 9'd292);
    do_move(RT, 1'b1, 1'b1);  chk("right_wrap_292", x, 9'd0);
    do_move(LF, 1'b1, 1'b1);  chk("left_wrap_0", x, 9'd293);

    m_x = 9'd293; m_y = 8'd235;
    scan(1'b0, 0, 5, "move_in_scan");

    m_x = 9'd0;
    scan(1'b0, 0, 0, "move_with_enable");

    scan(1'b0, 10, -1, "abort");
    scan(1'b0, 0, -1, "rescan");

    for (int i = 0; i < 50; i++)
      exp_q.push_back('{x: m_x + 9'(i % W), y: m_y + 8'(i / W), c: SP});
    enable = 1'b1;
    repeat (50) step();
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_plot", plot, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_x", x, 9'd0);
    chk("async_rst_y", y, 8'd100);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("async_rst_hold_done", done, 1'b0);
    end
    chk("async_rst_queue_left", exp_q.size(), 0);
    resetn = 1'b1;
    step(); step();
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_plot", plot, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
